// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited requests
// to instruction memory, buffers in-order responses in a small FIFO and hands
// {instr, pc} to decode. A redirect flushes the FIFO and marks every response
// still in flight as wrong-path so it is dropped on arrival.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];

    logic [CW:0] used;
    logic        req_fire;
    logic        push;
    logic        pop;

    // Credit comes from registered counts only, so a pop never frees a slot
    // for a request in the same cycle.
    assign used           = {1'b0, occ_q} + {1'b0, out_q};
    assign imem_req_valid = !rst && !redirect_valid && (used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fpc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push     = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign id_valid = (occ_q != '0) && !redirect_valid;
    assign pop      = id_valid && id_ready;
    assign id_instr = instr_q[rd_q];
    assign id_pc    = pc_q[rd_q];

    // Next-state for PCs, counters and FIFO pointers; redirect overrides all.
    always_comb begin
        fpc_d    = fpc_q;
        rsp_pc_d = rsp_pc_q;
        occ_d    = occ_q;
        out_d    = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d   = drop_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        if (redirect_valid) begin
            fpc_d    = redirect_pc;
            rsp_pc_d = redirect_pc;
            occ_d    = '0;
            wr_d     = '0;
            rd_d     = '0;
            // Pending drops are already a subset of outstanding, so after a
            // redirect every response still in flight is wrong-path.
            drop_d   = out_q - CW'(imem_rsp_valid && (out_q != '0));
        end else begin
            if (req_fire)
                fpc_d = fpc_q + 32'd4;
            if (imem_rsp_valid && (drop_q != '0))
                drop_d = drop_q - CW'(1);
            if (push) begin
                wr_d     = wr_q + AW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop)
                rd_d = rd_q + AW'(1);
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q    <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            occ_q    <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rsp_pc_q <= rsp_pc_d;
            occ_q    <= occ_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[wr_q] <= imem_rsp_data;
            pc_q[wr_q]    <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small instruction-memory model of
// selectable latency (1 or 2 cycles) and an in-order scoreboard of expected
// fetch addresses and decode PCs.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int          checks = 0;
    int          errors = 0;
    int          nfire  = 0;
    int          npop   = 0;
    int          lat    = 1;
    logic [31:0] exp_fa = 32'h0;
    logic [31:0] exp_pc = 32'h0;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: accepted requests shift down a two-stage pipe; the
    // response is taken from stage 1 or 2 depending on lat.
    logic        m1_v, m2_v;
    logic [31:0] m1_a, m2_a;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_v <= 1'b0; m2_v <= 1'b0; m1_a <= '0; m2_a <= '0;
        end else begin
            m1_v <= imem_req_valid && imem_req_ready;
            m1_a <= imem_req_addr;
            m2_v <= m1_v;
            m2_a <= m1_a;
        end
    end
    assign imem_rsp_valid = (lat == 1) ? m1_v : m2_v;
    assign imem_rsp_data  = ifn((lat == 1) ? m1_a : m2_a);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock cycle: score any fire/pop against the model, then advance.
    task automatic cyc();
        #1;
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_fa);
            exp_fa += 32'd4;
            nfire++;
        end
        if (id_valid && id_ready) begin
            chk("id_pc", id_pc, exp_pc);
            chk("id_instr", id_instr, ifn(exp_pc));
            exp_pc += 32'd4;
            npop++;
        end
        if (redirect_valid) begin
            exp_fa = redirect_pc;
            exp_pc = redirect_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_fa = 32'h0;
        exp_pc = 32'h0;
    endtask

    int base;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; id_ready = 1'b0;
        #2;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_id_valid",  {31'b0, id_valid}, 32'd0);
        chk("rst_id_instr",  id_instr, 32'd0);
        chk("rst_id_pc",     id_pc, 32'd0);

        // Zero-wait memory: first request in cycle 0, id_valid in cycle 2.
        @(posedge clk); #1;
        rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
        #1;
        chk("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("c0_req_addr",  imem_req_addr, 32'h0);
        chk("c0_id_valid",  {31'b0, id_valid}, 32'd0);
        cyc();
        #1;
        chk("c1_req_addr",  imem_req_addr, 32'h4);
        chk("c1_id_valid",  {31'b0, id_valid}, 32'd0);
        cyc();
        #1;
        chk("c2_id_valid",  {31'b0, id_valid}, 32'd1);
        repeat (12) cyc();

        // Decode stalled: exactly DEPTH requests, then fetch blocks at 8.
        do_reset();
        id_ready = 1'b0; nfire = 0;
        repeat (10) cyc();
        chk("stall_nfire", nfire, 32'd2);
        #1;
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_hold_addr", imem_req_addr, 32'h8);
        id_ready = 1'b1;
        repeat (10) cyc();

        // Memory not ready for 3 cycles: address holds, fpc does not move.
        imem_req_ready = 1'b0; base = nfire;
        repeat (3) begin
            #1;
            chk("nready_addr", imem_req_addr, exp_fa);
            cyc();
        end
        chk("nready_nfire", nfire - base, 32'd0);
        imem_req_ready = 1'b1;
        repeat (6) cyc();

        // Redirect with one buffered and one in flight (2-cycle memory).
        do_reset();
        lat = 2; id_ready = 1'b0;
        imem_req_ready = 1'b1; cyc();   // fire 0x0
        imem_req_ready = 1'b0; cyc();
        imem_req_ready = 1'b1; cyc();   // rsp 0x0 arrives, fire 0x4
        imem_req_ready = 1'b0;
        #1;
        chk("rd1_buffered", {31'b0, id_valid}, 32'd1);
        chk("rd1_head_pc",  id_pc, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("rd1_id_valid",  {31'b0, id_valid}, 32'd0);
        chk("rd1_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
        #1;
        chk("rd1_flushed",   {31'b0, id_valid}, 32'd0);
        chk("rd1_next_addr", imem_req_addr, 32'h100);
        base = npop;
        repeat (10) cyc();
        chk("rd1_delivered", {31'b0, (npop > base)}, 32'd1);

        // Redirect in the same cycle as a response while decode is ready.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
        cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        chk("rd2_rsp_valid", {31'b0, imem_rsp_valid}, 32'd1);
        chk("rd2_id_valid",  {31'b0, id_valid}, 32'd0);
        chk("rd2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("rd2_next_addr", imem_req_addr, 32'h200);
        base = npop;
        repeat (8) cyc();
        chk("rd2_delivered", {31'b0, (npop > base)}, 32'd1);

        // PC wrap: fetch past 32'hFFFF_FFFC rolls over to 0.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc();
        redirect_valid = 1'b0;
        base = npop;
        repeat (12) cyc();
        chk("wrap_delivered", {31'b0, (npop - base >= 4)}, 32'd1);

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("arst_id_valid",  {31'b0, id_valid}, 32'd0);
        chk("arst_id_instr",  id_instr, 32'd0);
        chk("arst_id_pc",     id_pc, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; exp_fa = 32'h0; exp_pc = 32'h0;
        #1;
        chk("arst_rel_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("arst_rel_addr",  imem_req_addr, 32'h0);
        repeat (8) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
